// File: rtl/wasm_mem_responder.sv
// Byte-wide RAM on the responder side of the CPU memory bus: fixed-latency reads
// with a one-cycle ready pulse, single-cycle writes, sticky out-of-range flag.
module wasm_mem_responder #(
  parameter int ADDR_WIDTH   = 10,
  parameter int READ_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [7:0]  data_in,
  input  logic        memory_write_en,
  input  logic        memory_read_en,
  output logic [7:0]  data_out,
  output logic        memory_ready,
  output logic        err
);

  localparam int         DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [3:0] CNT_LOAD = 4'(READ_LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state_r, state_nxt_s;
  logic [3:0]  cnt_r, cnt_nxt_s;
  logic [31:0] raddr_r, raddr_nxt_s;
  logic        rd_en_s, wr_en_s, wr_ok_s, sample_s, resp_enter_s, err_set_s;
  logic [7:0]  rd_data_s;
  logic [7:0]  ram_r [DEPTH];

  function automatic logic in_range(input logic [31:0] a);
    return (a >> ADDR_WIDTH) == 32'd0;
  endfunction

  // A halted CPU drives X/Z on the strobes; only a clean 1 counts as asserted.
  assign rd_en_s      = (memory_read_en === 1'b1);
  assign wr_en_s      = (memory_write_en === 1'b1);
  assign wr_ok_s      = wr_en_s && in_range(addr);
  assign resp_enter_s = (state_nxt_s == ST_RESP);
  assign err_set_s    = (wr_en_s && !in_range(addr)) || (sample_s && !in_range(addr));

  // Next-state, latency counter and captured read address.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    raddr_nxt_s = raddr_r;
    sample_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (rd_en_s) begin
          sample_s    = 1'b1;
          raddr_nxt_s = addr;
          if (READ_LATENCY == 1) begin
            state_nxt_s = ST_RESP;
            cnt_nxt_s   = 4'd0;
          end else begin
            state_nxt_s = ST_WAIT;
            cnt_nxt_s   = CNT_LOAD;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!rd_en_s) begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = 4'd0;
        end else if (cnt_r <= 4'd1) begin
          state_nxt_s = ST_RESP;
          cnt_nxt_s   = 4'd0;
        end else begin
          cnt_nxt_s   = cnt_r - 4'd1;
        end
      end
      ST_RESP: begin
        // No sampling here, so ready always drops for a cycle between responses.
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 4'd0;
      end
    endcase
  end

  // Response byte: out-of-range reads return zero, a same-edge write wins over RAM.
  always_comb begin
    rd_data_s = 8'h00;
    if (!in_range(raddr_nxt_s)) begin
      rd_data_s = 8'h00;
    end else if (wr_en_s && (addr == raddr_nxt_s)) begin
      rd_data_s = data_in;
    end else begin
      rd_data_s = ram_r[raddr_nxt_s[ADDR_WIDTH-1:0]];
    end
  end

  // Control state, registered outputs and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 4'd0;
      raddr_r      <= 32'd0;
      memory_ready <= 1'b0;
      data_out     <= 8'h00;
      err          <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      cnt_r        <= cnt_nxt_s;
      raddr_r      <= raddr_nxt_s;
      memory_ready <= resp_enter_s;
      err          <= err | err_set_s;
      if (resp_enter_s) begin
        data_out <= rd_data_s;
      end else begin
        data_out <= data_out;
      end
    end
  end

  // RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      ram_r[addr[ADDR_WIDTH-1:0]] <= data_in;
    end
  end

endmodule
